// File: rtl/vga_pkg.sv
// Shared VGA grid constants and host-board placement definitions.
package vga_pkg;

   // Host grid origin and extent in pixels
   localparam int unsigned CHAR_X_HOST = 48;
   localparam int unsigned CHAR_Y_HOST = 80;
   localparam int unsigned CHAR_LENGTH = 320;
   localparam int unsigned CHAR_HEIGHT = 320;

   // Board geometry: 10x10 cells of 32x32 pixels
   localparam int unsigned BOARD_COLS  = 10;
   localparam int unsigned BOARD_CELLS = 100;
   localparam int unsigned CELL_SHIFT  = 5;

   // Datapath widths
   localparam int unsigned COORD_W = 12;
   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned IDX_W   = 4;

   // Placer state, shared with the drawing and game-control blocks
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CALC   = 3'd1,
      WAIT   = 3'd2,
      DECIDE = 3'd3,
      WRITE  = 3'd4,
      CLEAR  = 3'd5
   } placer_state_e;

   // Board RAM index shared by writer and drawing paths
   function automatic logic [ADDR_W-1:0] cell_index(input logic [IDX_W-1:0] col,
                                                    input logic [IDX_W-1:0] row);
      return ADDR_W'(col) + ADDR_W'(BOARD_COLS) * ADDR_W'(row);
   endfunction

endpackage

// File: rtl/ship_placer.sv
// Converts host-grid mouse clicks into single-cell board RAM writes and sweeps the board clear.
module ship_placer
   import vga_pkg::*;
#(
   parameter int unsigned MAX_CELLS = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] xpos,
   input  logic [COORD_W-1:0] ypos,
   input  logic               mouse_left,
   input  logic               enable,
   input  logic               clear,
   output logic [ADDR_W-1:0]  cell_addr,
   input  logic               cell_rd_data,
   output logic               cell_we,
   output logic               cell_wdata,
   output logic [CNT_W-1:0]   placed_cnt,
   output logic               full,
   output logic               placed,
   output logic               reject,
   output logic               busy
);

   localparam logic [COORD_W-1:0] X_LO = COORD_W'(CHAR_X_HOST);
   localparam logic [COORD_W-1:0] X_HI = COORD_W'(CHAR_X_HOST + CHAR_LENGTH);
   localparam logic [COORD_W-1:0] Y_LO = COORD_W'(CHAR_Y_HOST);
   localparam logic [COORD_W-1:0] Y_HI = COORD_W'(CHAR_Y_HOST + CHAR_HEIGHT);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(BOARD_CELLS - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_CELLS);

   placer_state_e      state_q, state_d;
   logic               mouse_q;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               we_q, we_d;
   logic               wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               placed_q, placed_d;
   logic               reject_q, reject_d;
   logic               busy_q, busy_d;

   logic               click_c;
   logic               full_c;
   logic               in_range_c;
   logic [COORD_W-1:0] dx_c, dy_c;
   logic [IDX_W-1:0]   col_c, row_c;
   logic [ADDR_W-1:0]  calc_addr_c;

   // Rising edge of the left button against the previous-cycle sample
   assign click_c = mouse_left & ~mouse_q;
   assign full_c  = (cnt_q == CNT_MAX);

   // Grid-relative offsets and cell index of the latched click
   always_comb begin
      dx_c        = x_q - X_LO;
      dy_c        = y_q - Y_LO;
      in_range_c  = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
      col_c       = IDX_W'(dx_c >> CELL_SHIFT);
      row_c       = IDX_W'(dy_c >> CELL_SHIFT);
      calc_addr_c = cell_index(col_c, row_c);
   end

   // State register, button history and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mouse_q  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= 1'b0;
         cnt_q    <= '0;
         placed_q <= 1'b0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mouse_q  <= mouse_left;
         x_q      <= x_d;
         y_q      <= y_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         placed_q <= placed_d;
         reject_q <= reject_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state and next-output decode; pulses default low every cycle
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      addr_d   = addr_q;
      we_d     = 1'b0;
      wdata_d  = 1'b0;
      cnt_d    = cnt_q;
      placed_d = 1'b0;
      reject_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d = CLEAR;
               addr_d  = '0;
               we_d    = 1'b1;
            end else if (click_c && enable) begin
               x_d     = xpos;
               y_d     = ypos;
               state_d = CALC;
            end
         end
         CALC: begin
            if (in_range_c) begin
               addr_d  = calc_addr_c;
               state_d = WAIT;
            end else begin
               reject_d = 1'b1;
               state_d  = IDLE;
            end
         end
         WAIT: begin
            state_d = DECIDE;
         end
         DECIDE: begin
            if (cell_rd_data || full_c) begin
               reject_d = 1'b1;
               state_d  = IDLE;
            end else begin
               we_d     = 1'b1;
               wdata_d  = 1'b1;
               placed_d = 1'b1;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = IDLE;
         end
         CLEAR: begin
            if (addr_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               we_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign cell_addr  = addr_q;
   assign cell_we    = we_q;
   assign cell_wdata = wdata_q;
   assign placed_cnt = cnt_q;
   assign placed     = placed_q;
   assign reject     = reject_q;
   assign busy       = busy_q;
   assign full       = full_c;

endmodule

// File: tb/tb_ship_placer.sv
// Bench for ship_placer: board RAM model plus a coordinate-level reference model.
module tb_ship_placer;
   import vga_pkg::*;

   localparam int MAXC = 20;
   localparam int X0   = int'(CHAR_X_HOST);
   localparam int Y0   = int'(CHAR_Y_HOST);

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic        mouse_left, enable, clear;
   logic [6:0]  cell_addr;
   logic        cell_rd_data;
   logic        cell_we, cell_wdata;
   logic [4:0]  placed_cnt;
   logic        full, placed, reject, busy;

   int checks = 0;
   int errors = 0;

   // Board RAM environment
   logic mem [BOARD_CELLS];
   logic ram_init;
   int   ones_written = 0;
   int   zeros_written = 0;

   // Reference model: occupancy as seen from the game's rules
   bit occ [BOARD_CELLS];
   int exp_cnt;

   always #5 clk = ~clk;

   ship_placer #(.MAX_CELLS(MAXC)) dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
      .mouse_left(mouse_left), .enable(enable), .clear(clear),
      .cell_addr(cell_addr), .cell_rd_data(cell_rd_data),
      .cell_we(cell_we), .cell_wdata(cell_wdata),
      .placed_cnt(placed_cnt), .full(full), .placed(placed),
      .reject(reject), .busy(busy)
   );

   // Synchronous-read board RAM with write counters
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < int'(BOARD_CELLS); i++) mem[i] <= 1'b0;
         cell_rd_data <= 1'b0;
      end else begin
         cell_rd_data <= (int'(cell_addr) < int'(BOARD_CELLS)) ? mem[cell_addr] : 1'b0;
         if (cell_we) begin
            if (int'(cell_addr) < int'(BOARD_CELLS)) mem[cell_addr] <= cell_wdata;
            if (cell_wdata) ones_written <= ones_written + 1;
            else            zeros_written <= zeros_written + 1;
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One click transaction, checked cycle by cycle against the model
   task automatic do_click(input int x, input int y, input bit drop_en);
      bit inr;
      bit legal;
      int a;
      int w1;
      inr = (x >= X0) && (x < X0 + 320) && (y >= Y0) && (y < Y0 + 320);
      a   = ((y - Y0) / 32) * 10 + (x - X0) / 32;
      w1  = ones_written;
      xpos = 12'(x);
      ypos = 12'(y);
      enable = 1'b1;
      mouse_left = 1'b1;
      tick();                                   // cycle 1
      check("busy_after_click", int'(busy), 1);
      mouse_left = 1'b0;
      if (drop_en) enable = 1'b0;
      tick();                                   // cycle 2
      if (!inr) begin
         check("oor_reject", int'(reject), 1);
         check("oor_no_we", int'(cell_we), 0);
         check("oor_idle", int'(busy), 0);
         tick();
         check("oor_reject_pulse", int'(reject), 0);
         check("oor_no_write", ones_written, w1);
         enable = 1'b1;
         return;
      end
      check("calc_addr", int'(cell_addr), a);
      check("calc_no_reject", int'(reject), 0);
      legal = !occ[a] && (exp_cnt < MAXC);
      tick();                                   // cycle 3
      check("wait_no_we", int'(cell_we), 0);
      tick();                                   // cycle 4
      if (legal) begin
         check("write_we", int'(cell_we), 1);
         check("write_wdata", int'(cell_wdata), 1);
         check("write_addr", int'(cell_addr), a);
         check("write_placed", int'(placed), 1);
         check("write_no_reject", int'(reject), 0);
      end else begin
         check("occ_reject", int'(reject), 1);
         check("occ_no_we", int'(cell_we), 0);
         check("occ_no_placed", int'(placed), 0);
      end
      tick();                                   // cycle 5
      if (legal) begin
         occ[a] = 1'b1;
         exp_cnt++;
      end
      check("done_idle", int'(busy), 0);
      check("done_we_low", int'(cell_we), 0);
      check("placed_cnt", int'(placed_cnt), exp_cnt);
      check("full_flag", int'(full), (exp_cnt == MAXC) ? 1 : 0);
      check("write_count", ones_written, w1 + (legal ? 1 : 0));
      enable = 1'b1;
   endtask

   task automatic click_cell(input int c, input bit drop_en);
      do_click(X0 + (c % 10) * 32 + int'($urandom_range(0, 31)),
               Y0 + (c / 10) * 32 + int'($urandom_range(0, 31)), drop_en);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, int'(cell_addr), 0);
      check({tag, "_we"}, int'(cell_we), 0);
      check({tag, "_wdata"}, int'(cell_wdata), 0);
      check({tag, "_cnt"}, int'(placed_cnt), 0);
      check({tag, "_placed"}, int'(placed), 0);
      check({tag, "_reject"}, int'(reject), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_full"}, int'(full), 0);
   endtask

   initial begin
      int iter;
      int wsnap;
      int nz;
      int free_c;
      rst = 1'b1; ram_init = 1'b1;
      xpos = '0; ypos = '0; mouse_left = 1'b0; enable = 1'b1; clear = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < int'(BOARD_CELLS); i++) occ[i] = 1'b0;
      repeat (3) tick();
      ram_init = 1'b0;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Directed placements and boundaries
      do_click(X0 + 70, Y0 + 40, 1'b0);
      do_click(X0 + 70, Y0 + 40, 1'b0);
      do_click(X0 + 320, Y0, 1'b0);
      do_click(X0 - 1, Y0 + 5, 1'b0);
      do_click(X0 + 319, Y0 + 319, 1'b0);
      do_click(X0 + 5, Y0 + 320, 1'b0);

      // Click with enable low is ignored
      enable = 1'b0; mouse_left = 1'b1;
      tick(); tick();
      check("disabled_click_idle", int'(busy), 0);
      mouse_left = 1'b0; enable = 1'b1;
      tick();

      // Random fill up to the limit, with occasional misses and enable drops
      iter = 0;
      while (exp_cnt < MAXC && iter < 300) begin
         iter++;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1)
               do_click(X0 + 320 + int'($urandom_range(0, 200)), Y0 + int'($urandom_range(0, 319)), 1'b0);
            else
               do_click(X0 + int'($urandom_range(0, 319)), Y0 - 1 - int'($urandom_range(0, 40)), 1'b0);
         end else begin
            click_cell(int'($urandom_range(0, 99)), 1'(($urandom_range(0, 1))));
         end
      end
      check("fill_reached", exp_cnt, MAXC);
      check("full_set", int'(full), 1);
      free_c = 0;
      while (free_c < 99 && occ[free_c]) free_c++;
      click_cell(free_c, 1'b0);

      // Clear with a simultaneous click edge
      wsnap = ones_written;
      clear = 1'b1; mouse_left = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 0; k < 100; k++) begin
         check("clr_we", int'(cell_we), 1);
         check("clr_wdata", int'(cell_wdata), 0);
         check("clr_addr", int'(cell_addr), k);
         tick();
      end
      check("clr_end_we", int'(cell_we), 0);
      check("clr_cnt", int'(placed_cnt), 0);
      check("clr_busy", int'(busy), 0);
      check("clr_click_dropped", ones_written, wsnap);
      nz = 0;
      for (int i = 0; i < int'(BOARD_CELLS); i++) if (mem[i]) nz++;
      check("clr_ram_empty", nz, 0);
      for (int i = 0; i < int'(BOARD_CELLS); i++) occ[i] = 1'b0;
      exp_cnt = 0;
      mouse_left = 1'b0;
      tick();

      // Reset in the middle of a clear sweep
      click_cell(70, 1'b0);
      click_cell(5, 1'b0);
      click_cell(33, 1'b0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (49) tick();
      check("midclr_we", int'(cell_we), 1);
      check("midclr_addr", int'(cell_addr), 49);
      rst = 1'b1; mouse_left = 1'b1;
      tick();
      check_reset_outputs("abort");
      wsnap = ones_written + zeros_written;
      tick(); tick();
      check("abort_no_writes", ones_written + zeros_written, wsnap);
      rst = 1'b0; mouse_left = 1'b0;
      tick(); tick();
      check("post_rst_idle", int'(busy), 0);
      check("post_rst_no_writes", ones_written + zeros_written, wsnap);
      for (int i = 0; i < 50; i++) occ[i] = 1'b0;
      exp_cnt = 0;
      click_cell(5, 1'b0);
      click_cell(70, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
